// File: rtl/midi_gate_decoder.sv
// MIDI byte-stream parser producing a monophonic gate, note/velocity and the
// four ADSR envelope parameters driven by control changes 72/73/75/79.
module midi_gate_decoder #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        key_state,
  output logic [6:0]  note,
  output logic [6:0]  velocity,
  output logic        note_evt,
  output logic [15:0] attack_amt,
  output logic [15:0] decay_amt,
  output logic [15:0] sustain_amt,
  output logic [15:0] rel_amt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } state_t;

  // Command is the status high nibble with its always-set MSB dropped.
  localparam logic [2:0] CMD_NOTE_OFF = 3'd0;
  localparam logic [2:0] CMD_NOTE_ON  = 3'd1;
  localparam logic [2:0] CMD_CC       = 3'd3;
  localparam logic [2:0] CMD_PROG     = 3'd4;
  localparam logic [2:0] CMD_CHAN_AT  = 3'd5;

  localparam logic [6:0] CC_REL     = 7'd72;
  localparam logic [6:0] CC_ATTACK  = 7'd73;
  localparam logic [6:0] CC_DECAY   = 7'd75;
  localparam logic [6:0] CC_SUSTAIN = 7'd79;
  localparam logic [6:0] CC_ALL_OFF = 7'd123;

  localparam logic [15:0] ATTACK_RST  = 16'h0100;
  localparam logic [15:0] DECAY_RST   = 16'h0040;
  localparam logic [15:0] SUSTAIN_RST = 16'h8000;
  localparam logic [15:0] REL_RST     = 16'h0040;

  // Replicate a 7-bit CC value across 16 bits; optionally keep it nonzero.
  function automatic logic [15:0] expand_cc(input logic [6:0] v, input logic floor_one);
    logic [15:0] e;
    e = {v, v, v[6:5]};
    if (floor_one && (e == 16'h0000)) begin
      expand_cc = 16'h0001;
    end else begin
      expand_cc = e;
    end
  endfunction

  state_t      state_r, state_nxt_s;
  logic [2:0]  cmd_r, cmd_nxt_s;
  logic        discard_r, discard_nxt_s;
  logic [6:0]  d1_r, d1_nxt_s;
  logic        msg_done_s;

  logic        is_rt_s, is_status_s, is_data_s, chan_ok_s;

  logic        key_r, evt_r;
  logic [6:0]  note_r, vel_r;
  logic [15:0] attack_r, decay_r, sustain_r, rel_r;

  logic        exec_s, note_on_s, off_req_s, gate_off_s, cc_s;
  logic [6:0]  d2_s;

  // Byte classification; realtime bytes are invisible to the parser.
  always_comb begin
    is_rt_s     = (rx_data[7:3] == 5'b11111);
    is_status_s = rx_valid & rx_data[7] & ~is_rt_s;
    is_data_s   = rx_valid & ~rx_data[7];
    chan_ok_s   = OMNI || (rx_data[3:0] == CHANNEL);
  end

  // Parser state register with running status, discard flag and first data byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cmd_r     <= 3'd0;
      discard_r <= 1'b0;
      d1_r      <= 7'd0;
    end else begin
      state_r   <= state_nxt_s;
      cmd_r     <= cmd_nxt_s;
      discard_r <= discard_nxt_s;
      d1_r      <= d1_nxt_s;
    end
  end

  // Parser next-state logic.
  always_comb begin
    state_nxt_s   = state_r;
    cmd_nxt_s     = cmd_r;
    discard_nxt_s = discard_r;
    d1_nxt_s      = d1_r;
    msg_done_s    = 1'b0;
    if (is_status_s) begin
      // Any status byte ends sysex without being taken as a new running status.
      if (state_r == ST_SYSEX) begin
        state_nxt_s = ST_IDLE;
      end else if (rx_data[7:4] != 4'hF) begin
        state_nxt_s   = ST_WAIT_D1;
        cmd_nxt_s     = rx_data[6:4];
        discard_nxt_s = ~chan_ok_s;
      end else if (rx_data == 8'hF0) begin
        state_nxt_s = ST_SYSEX;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else if (is_data_s) begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_WAIT_D1: begin
          d1_nxt_s = rx_data[6:0];
          if ((cmd_r == CMD_PROG) || (cmd_r == CMD_CHAN_AT)) begin
            state_nxt_s = ST_WAIT_D1;
          end else begin
            state_nxt_s = ST_WAIT_D2;
          end
        end
        ST_WAIT_D2: begin
          msg_done_s  = 1'b1;
          state_nxt_s = ST_WAIT_D1;
        end
        ST_SYSEX: begin
          state_nxt_s = ST_SYSEX;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Decode the completed three-byte message into output actions.
  always_comb begin
    exec_s     = msg_done_s & ~discard_r;
    d2_s       = rx_data[6:0];
    note_on_s  = 1'b0;
    off_req_s  = 1'b0;
    cc_s       = 1'b0;
    gate_off_s = 1'b0;
    if (exec_s) begin
      case (cmd_r)
        CMD_NOTE_ON: begin
          if (d2_s != 7'd0) begin
            note_on_s = 1'b1;
          end else begin
            off_req_s = 1'b1;
          end
        end
        CMD_NOTE_OFF: begin
          off_req_s = 1'b1;
        end
        CMD_CC: begin
          cc_s = 1'b1;
        end
        default: begin
          note_on_s = 1'b0;
        end
      endcase
    end else begin
      note_on_s = 1'b0;
    end
    // Only the most recent note may release the gate.
    if (off_req_s && (d1_r == note_r) && key_r) begin
      gate_off_s = 1'b1;
    end else if (cc_s && (d1_r == CC_ALL_OFF) && key_r) begin
      gate_off_s = 1'b1;
    end else begin
      gate_off_s = 1'b0;
    end
  end

  // Registered gate, note, velocity and event pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_r  <= 1'b0;
      note_r <= 7'd0;
      vel_r  <= 7'd0;
      evt_r  <= 1'b0;
    end else begin
      evt_r <= note_on_s | gate_off_s;
      if (note_on_s) begin
        key_r  <= 1'b1;
        note_r <= d1_r;
        vel_r  <= d2_s;
      end else if (gate_off_s) begin
        key_r <= 1'b0;
      end
    end
  end

  // Registered envelope parameters updated by their control changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      attack_r  <= ATTACK_RST;
      decay_r   <= DECAY_RST;
      sustain_r <= SUSTAIN_RST;
      rel_r     <= REL_RST;
    end else if (cc_s) begin
      case (d1_r)
        CC_ATTACK:  attack_r  <= expand_cc(d2_s, 1'b1);
        CC_DECAY:   decay_r   <= expand_cc(d2_s, 1'b1);
        CC_SUSTAIN: sustain_r <= expand_cc(d2_s, 1'b0);
        CC_REL:     rel_r     <= expand_cc(d2_s, 1'b1);
        default:    attack_r  <= attack_r;
      endcase
    end
  end

  assign key_state   = key_r;
  assign note        = note_r;
  assign velocity    = vel_r;
  assign note_evt    = evt_r;
  assign attack_amt  = attack_r;
  assign decay_amt   = decay_r;
  assign sustain_amt = sustain_r;
  assign rel_amt     = rel_r;

endmodule
